// File: rtl/binning_pkg.sv
// Shared definitions for the binning datapath: bin-index width and the
// transmit framer state encoding.
package binning_pkg;

    localparam int unsigned BIN_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DROP = 2'd2
    } tx_state_t;

endpackage

// File: rtl/fft_frame_tx_if.sv
// AXI-stream style output bus of the FFT framer.
//   m_tvalid  beat valid           (master -> slave)
//   m_tready  downstream ready     (slave  -> master)
//   m_tdata   bin sample           (master -> slave)
//   m_tlast   last bin of frame    (master -> slave)
//   m_tuser   bin index            (master -> slave)
interface fft_frame_tx_if
    import binning_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) ();

    logic              m_tvalid;
    logic              m_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic [BIN_W-1:0]  m_tuser;

    modport master (
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        output m_tuser,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        input  m_tuser,
        output m_tready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered output stage.
//   clk, areset_n  clock, async active-low reset
//   push, din      write side; a push while full is ignored
//   full           total occupancy (storage + output stage) equals DEPTH
//   pop            consume the head entry when it is present
//   empty          no entry presented on dout
//   dout           head entry, registered
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic [CW-1:0]    occ;
    logic             out_valid;
    logic             push_ok;
    logic             pop_ok;
    logic             load;

    // occ counts the output stage too, so DEPTH is the true capacity
    assign full    = (occ == CW'(DEPTH));
    assign empty   = !out_valid;
    assign push_ok = push && !full;
    assign pop_ok  = pop && out_valid;
    // refill the output stage whenever it is free or being consumed
    assign load    = (mem_cnt != '0) && (!out_valid || pop_ok);

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, counters and output stage
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (load) begin
                rd_ptr    <= AW'(rd_ptr + AW'(1));
                dout      <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (pop_ok) begin
                out_valid <= 1'b0;
            end
            mem_cnt <= CW'(mem_cnt + CW'(push_ok) - CW'(load));
            occ     <= CW'(occ + CW'(push_ok) - CW'(pop_ok));
        end
    end

endmodule

// File: rtl/fft_frame_tx.sv
// Transmit-side framer: turns the FFT core's unthrottled bin strobes into a
// framed, backpressured stream carrying the bin index of every beat.
//   clk, areset_n        clock, async active-low reset
//   en                   framing enable, honoured only at frame boundaries
//   in_valid, in_data    FFT bin strobe and sample
//   m_axis               output stream (tvalid/tready/tdata/tlast/tuser)
//   frame_count          completed output frames (beats sent with tlast)
//   overflow             sticky: a bin was dropped because the FIFO was full
module fft_frame_tx
    import binning_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NFFT       = 1024,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    fft_frame_tx_if.master    m_axis,
    output logic [BIN_W-1:0]  frame_count,
    output logic              overflow
);

    localparam int unsigned BW = $clog2(NFFT);
    localparam int unsigned EW = 1 + BW + DATA_W;

    tx_state_t     state;
    logic [BW-1:0] in_bin;
    logic          bin_first;
    logic          bin_last;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] fifo_din;
    logic [EW-1:0] fifo_dout;

    assign bin_first = (in_bin == '0);
    assign bin_last  = (in_bin == BW'(NFFT - 1));
    // tlast is stored alongside the entry so the output is a plain register
    assign fifo_din  = {bin_last, in_bin, in_data};

    // Write decision for the current strobe
    always_comb begin
        push = 1'b0;
        unique case (state)
            IDLE:    push = in_valid && en && bin_first && !fifo_full;
            RUN:     push = in_valid && !fifo_full;
            DROP:    push = in_valid && en && bin_first && !fifo_full;
            default: push = 1'b0;
        endcase
    end

    // Bin counter, framing FSM, frame counter and overflow flag
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= IDLE;
            in_bin      <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            // alignment follows the strobes regardless of acceptance
            if (in_valid) begin
                in_bin <= BW'(in_bin + BW'(1));
            end

            unique case (state)
                IDLE: begin
                    if (push) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (fifo_full) begin
                            overflow <= 1'b1;
                            state    <= DROP;
                        end else if (bin_last && !en) begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (in_valid && bin_first) begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (!fifo_full) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (m_axis.m_tvalid && m_axis.m_tready && m_axis.m_tlast) begin
                frame_count <= BIN_W'(frame_count + BIN_W'(1));
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .push     (push),
        .din      (fifo_din),
        .full     (fifo_full),
        .pop      (m_axis.m_tready),
        .empty    (fifo_empty),
        .dout     (fifo_dout)
    );

    assign m_axis.m_tvalid = !fifo_empty;
    assign m_axis.m_tlast  = fifo_dout[EW-1];
    assign m_axis.m_tuser  = BIN_W'(fifo_dout[DATA_W +: BW]);
    assign m_axis.m_tdata  = fifo_dout[DATA_W-1:0];

endmodule

// File: tb/tb_fft_frame_tx.sv
// Directed bench for fft_frame_tx with NFFT=8, FIFO_DEPTH=4, DATA_W=32.
module tb_fft_frame_tx;

    localparam int unsigned DW = 32;
    localparam int unsigned NF = 8;
    localparam int unsigned FD = 4;

    logic          clk      = 1'b0;
    logic          areset_n = 1'b0;
    logic          en       = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [31:0]   frame_count;
    logic          overflow;

    fft_frame_tx_if #(.DATA_W(DW)) axis ();

    fft_frame_tx #(
        .DATA_W     (DW),
        .NFFT       (NF),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .m_axis      (axis),
        .frame_count (frame_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // beat = {tlast, tuser, tdata}
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    logic        held_v = 1'b0;
    logic [64:0] held   = '0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] bt(input int user, input logic [31:0] data);
        logic last;
        last = (user == NF - 1);
        return {last, 32'(user), data};
    endfunction

    // Beat capture and hold-stability check, sampled mid-cycle
    always @(negedge clk) begin
        if (!areset_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold", 96'({axis.m_tvalid, axis.m_tlast, axis.m_tuser, axis.m_tdata}),
                      96'({1'b1, held}));
            end
            if (axis.m_tvalid && axis.m_tready) begin
                got_q.push_back({axis.m_tlast, axis.m_tuser, axis.m_tdata});
            end
            held_v = axis.m_tvalid && !axis.m_tready;
            held   = {axis.m_tlast, axis.m_tuser, axis.m_tdata};
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(1'b0, 32'h0);
    endtask

    task automatic check_beats(input string name);
        check({name, " count"}, 96'(got_q.size()), 96'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s beat%0d", name, i), 96'(got_q[i]), 96'(exp_q[i]));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " tvalid"}, 96'(axis.m_tvalid), 96'(0));
        check({name, " tdata"},  96'(axis.m_tdata),  96'(0));
        check({name, " tuser"},  96'(axis.m_tuser),  96'(0));
        check({name, " tlast"},  96'(axis.m_tlast),  96'(0));
        check({name, " fcount"}, 96'(frame_count),   96'(0));
        check({name, " ovf"},    96'(overflow),      96'(0));
    endtask

    initial begin
        axis.m_tready = 1'b0;
        #12;
        check_outputs_zero("reset");
        #10;
        areset_n = 1'b1;
        @(posedge clk);
        #1;

        // steady flow, two full frames
        en = 1'b1;
        axis.m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(bt(i % 8, 32'h100 + 32'(i)));
            cyc(1'b1, 32'h100 + 32'(i));
        end
        drain(10);
        check_beats("flow");
        check("flow fcount", 96'(frame_count), 96'(2));
        check("flow ovf", 96'(overflow), 96'(0));

        // en drops at bin 2: frame completes, nothing afterwards
        for (int i = 0; i < 16; i++) begin
            en = (i < 2);
            if (i < 8) exp_q.push_back(bt(i, 32'h200 + 32'(i)));
            cyc(1'b1, 32'h200 + 32'(i));
        end
        drain(10);
        check_beats("disable");
        check("disable fcount", 96'(frame_count), 96'(3));

        // en rises at bin 3: output waits for the next bin 0
        for (int i = 0; i < 16; i++) begin
            en = (i >= 3);
            if (i >= 8) exp_q.push_back(bt(i - 8, 32'h300 + 32'(i)));
            cyc(1'b1, 32'h300 + 32'(i));
        end
        drain(10);
        check_beats("midfen");
        check("midfen fcount", 96'(frame_count), 96'(4));

        // backpressure: bins 0-3 held, bin 4 dropped, DROP until bin 0
        axis.m_tready = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h400 + 32'(i));
        check("bp ovf", 96'(overflow), 96'(1));
        check("bp tvalid", 96'(axis.m_tvalid), 96'(1));
        check("bp tuser", 96'(axis.m_tuser), 96'(0));
        check("bp none out", 96'(got_q.size()), 96'(0));
        for (int i = 0; i < 4; i++) exp_q.push_back(bt(i, 32'h400 + 32'(i)));
        for (int i = 8; i < 16; i++) exp_q.push_back(bt(i - 8, 32'h400 + 32'(i)));
        axis.m_tready = 1'b1;
        for (int i = 6; i < 16; i++) cyc(1'b1, 32'h400 + 32'(i));
        drain(10);
        check_beats("bp");
        check("bp fcount", 96'(frame_count), 96'(5));

        // ready toggling every cycle, one strobe every other cycle
        for (int i = 0; i < 8; i++) exp_q.push_back(bt(i, 32'h500 + 32'(i)));
        for (int c = 0; c < 40; c++) begin
            axis.m_tready = c[0];
            cyc((c % 2 == 0) && (c < 16), 32'h500 + 32'(c / 2));
        end
        axis.m_tready = 1'b1;
        drain(4);
        check_beats("toggle");
        check("toggle fcount", 96'(frame_count), 96'(6));

        // reset at bin 5 with bins 2-4 buffered
        cyc(1'b1, 32'h600);
        cyc(1'b1, 32'h601);
        drain(3);
        axis.m_tready = 1'b0;
        for (int i = 2; i < 5; i++) cyc(1'b1, 32'h600 + 32'(i));
        check("prerst tvalid", 96'(axis.m_tvalid), 96'(1));
        check("prerst tuser", 96'(axis.m_tuser), 96'(2));
        #2;
        areset_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        got_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        axis.m_tready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(bt(i, 32'h700 + 32'(i)));
            cyc(1'b1, 32'h700 + 32'(i));
        end
        drain(10);
        check_beats("postrst");
        check("postrst fcount", 96'(frame_count), 96'(1));
        check("postrst ovf", 96'(overflow), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_frame_tx.md
# fft_frame_tx

Transmit-side framer for the binning datapath. It accepts the raw per-bin strobe stream from the FFT core (`in_valid`/`in_data`, one bin per strobe, no backpressure possible) and re-emits it as a framed, backpressured stream for downstream consumers. Each output beat carries its 32-bit bin index, matching the bin-number width the binning module uses, and `m_tlast` marks the final bin of each FFT frame. It sits between the FFT core and the binning/accumulation logic.

## Interface
- `DATA_W`, 32, bin sample width.
- `NFFT`, 1024, bins per frame; power of two, ≥ 4.
- `FIFO_DEPTH`, 16, elastic buffer depth; power of two, ≥ 2.
- `clk`  in  1  single clock for the whole block.
- `areset_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  framing enable; sampled only at frame boundaries.
- `in_valid`  in  1  FFT bin strobe.
- `in_data`  in  DATA_W  FFT bin sample.
- `m_tvalid`  out  1  output beat valid.
- `m_tready`  in  1  downstream ready.
- `m_tdata`  out  DATA_W  bin sample.
- `m_tlast`  out  1  high on bin NFFT-1.
- `m_tuser`  out  32  bin index, zero-extended.
- `frame_count`  out  32  count of completed output frames.
- `overflow`  out  1  sticky drop flag; cleared only by reset.

## Operation
- Input bin counter `in_bin` (width `$clog2(NFFT)`):
  - Increments on every `in_valid` in every state.
  - Wraps from NFFT-1 to 0.
  - Defines frame alignment independently of acceptance.
- FSM states: IDLE, RUN, DROP.
  - IDLE → RUN: `en` && `in_valid` && `in_bin`==0 && !full. That bin is written.
  - RUN: each `in_valid` writes {`in_data`, `in_bin`} into the FIFO.
    - If full on `in_valid`: sample dropped, `overflow`←1, go to DROP.
    - If `en`==0 when bin NFFT-1 is written: go to IDLE (current frame is finished first).
  - DROP: all input discarded.
    - → RUN at next `in_valid` with `in_bin`==0 && `en` && !full. That bin is written.
    - → IDLE at the same point if `en`==0.
- Truncated frames are emitted as-is, without `m_tlast`. Downstream detects them by the `m_tuser` discontinuity (next beat has index 0).
- Output follows AXI-stream rules:
  - Beat transfers on `m_tvalid` && `m_tready`.
  - `m_tdata`/`m_tuser`/`m_tlast` stay stable while `m_tvalid` && !`m_tready`.
  - `m_tvalid` never depends combinationally on `m_tready`.
- `m_tlast` = (stored index == NFFT-1).
- `frame_count` increments on each transferred beat with `m_tlast`; wraps at 2^32.

## Timing
- Reset values:
  - `m_tvalid`, `m_tdata`, `m_tuser`, `m_tlast`, `frame_count`, `overflow` = 0.
  - `in_bin` = 0, FSM = IDLE, FIFO empty.
- Latency: a sample written at edge N is visible on `m_tvalid` after edge N+1 (one cycle, registered output).
- Full is evaluated on the registered occupancy. A push while full is dropped even if a pop occurs in the same cycle.
- Push and pop in the same cycle with the FIFO not full: occupancy unchanged, both take effect.
- `en` deasserting mid-frame has no effect until bin NFFT-1. `en` asserting mid-frame waits for the next bin 0.
- Reset asserted mid-frame: all state cleared immediately (asynchronous). Output beats in flight are lost.

## Structure
- Shared package `binning_pkg` holds:
  - `BIN_W`=32.
  - The `tx_state_t` enum {IDLE, RUN, DROP}.
- Sub-module `sync_fifo` (parameters: width, depth):
  - Registered-output, single-clock FIFO.
  - Exposes `full`, `empty`, push/pop.
  - Stores {`in_data`, index}.
- Top level contains the counter, FSM, `frame_count` and `overflow` logic.

## Test plan
Directed scenarios use NFFT=8, FIFO_DEPTH=4, DATA_W=32.
- Steady flow:
  - Stimulus: `en`=1, `m_tready`=1, 16 consecutive `in_valid` with data = 0x100+i.
  - Required: 16 beats, `m_tuser` 0..7,0..7, `m_tlast` on beats 7 and 15, `frame_count`=2, `overflow`=0.
- Mid-frame enable:
  - Stimulus: `en` rises when `in_bin`=3.
  - Required: no output until the next bin 0; first beat has `m_tuser`=0.
- Backpressure:
  - Stimulus: `m_tready`=0 for 6 strobes starting at bin 0.
  - Required: bins 0-3 held; bin 4 dropped; `overflow`=1; DROP until next bin 0.
  - On release: 4 beats (0-3) with no `m_tlast`, then the next frame starts at `m_tuser`=0.
- Hold stability:
  - Stimulus: toggle `m_tready` every cycle over a full frame.
  - Required: each beat stays stable until accepted; 8 beats in order.
- Disable at end of frame:
  - Stimulus: `en`←0 at bin 2.
  - Required: bins 2-7 still emitted with `m_tlast` on 7; no further output.
- Reset mid-frame:
  - Stimulus: `areset_n` low at bin 5 with 3 beats buffered.
  - Required: all outputs 0 immediately; after release, output restarts at bin 0 of a fresh frame.
